// File: rtl/kara_pkg.sv
// Shared constants, widths and FSM encoding for the Curve25519 Karatsuba reducer.
// The optional raw-product output is enabled with KARA_REDUCE_RAW_OUT_EN.
package kara_pkg;

    localparam int H_W   = 254;
    localparam int L_W   = 256;
    localparam int M_W   = 258;
    localparam int P_W   = 510;
    localparam int OUT_W = 255;
    localparam int S1_W  = 261;
    localparam int S2_W  = 256;

    // 2^255 - 19: all ones above the low five bits 01101.
    localparam logic [OUT_W-1:0] P_MOD  = {{250{1'b1}}, 5'b01101};
    localparam int               C_FOLD = 19;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COMB  = 3'd1,
        ST_FOLD1 = 3'd2,
        ST_FOLD2 = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } kara_state_e;

endpackage

// File: rtl/kara_fold19.sv
// Combinational fold step lo + 19*hi, used because 2^255 == 19 (mod p).
// Shared by both fold stages of kara_reduce with different widths.
module kara_fold19
    import kara_pkg::*;
#(
    parameter int LO_W  = 255,
    parameter int HI_W  = 255,
    parameter int OUT_W = 261
) (
    input  logic [LO_W-1:0]  i_lo,
    input  logic [HI_W-1:0]  i_hi,
    output logic [OUT_W-1:0] o_sum
);

    localparam logic [OUT_W-1:0] W_C = OUT_W'(C_FOLD);

    logic [OUT_W-1:0] w_lo_ext;
    logic [OUT_W-1:0] w_hi_ext;

    assign w_lo_ext = OUT_W'(i_lo);
    assign w_hi_ext = OUT_W'(i_hi);
    assign o_sum    = w_lo_ext + w_hi_ext * W_C;

endmodule

// File: rtl/kara_reduce.sv
// Recombines Karatsuba partial products and reduces the product mod 2^255-19.
// Define KARA_REDUCE_RAW_OUT_EN to expose the unreduced product on out_raw.
module kara_reduce
    import kara_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [H_W-1:0]    H0,
    input  logic [L_W-1:0]    L0,
    input  logic [M_W-1:0]    M0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
`ifdef KARA_REDUCE_RAW_OUT_EN
    output logic [P_W-1:0]    out_raw,
`endif
    output kara_state_e       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never drops and payload never changes until that transfer.
    kara_state_e r_state;
    kara_state_e w_next_state;

    logic [H_W-1:0]   r_h0;
    logic [L_W-1:0]   r_l0;
    logic [M_W-1:0]   r_m0;
    logic [P_W-1:0]   r_p;
    logic [S1_W-1:0]  r_s1;
    logic [S2_W-1:0]  r_s2;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;

    logic             w_load_in;
    logic             w_load_p;
    logic             w_load_s1;
    logic             w_load_s2;
    logic             w_load_out;
    logic             w_out_xfer;

    logic [M_W-1:0]   w_mm;
    logic [P_W-1:0]   w_p;
    logic [S1_W-1:0]  w_s1;
    logic [S2_W-1:0]  w_s2;
    logic             w_ge_p;
    logic [OUT_W-1:0] w_sub_p;
    logic [OUT_W-1:0] w_final;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (in_valid) w_next_state = ST_COMB;
            ST_COMB:  w_next_state = ST_FOLD1;
            ST_FOLD1: w_next_state = ST_FOLD2;
            ST_FOLD2: w_next_state = ST_FINAL;
            ST_FINAL: w_next_state = ST_DONE;
            ST_DONE:  if (out_ready) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (r_state == ST_IDLE) && !rst;
        w_load_in  = (r_state == ST_IDLE) && in_valid;
        w_load_p   = (r_state == ST_COMB);
        w_load_s1  = (r_state == ST_FOLD1);
        w_load_s2  = (r_state == ST_FOLD2);
        w_load_out = (r_state == ST_FINAL);
        w_out_xfer = (r_state == ST_DONE) && out_ready;
    end

    // The middle term is kept at full input width; for legal inputs its top bit is zero.
    assign w_mm = r_m0 - M_W'(r_h0) - M_W'(r_l0);
    assign w_p  = (P_W'(r_h0) << 256) + (P_W'(w_mm) << 128) + P_W'(r_l0);

    kara_fold19 #(.LO_W(255), .HI_W(255), .OUT_W(S1_W)) u_fold1 (
        .i_lo  (r_p[254:0]),
        .i_hi  (r_p[509:255]),
        .o_sum (w_s1)
    );

    kara_fold19 #(.LO_W(255), .HI_W(6), .OUT_W(S2_W)) u_fold2 (
        .i_lo  (r_s1[254:0]),
        .i_hi  (r_s1[260:255]),
        .o_sum (w_s2)
    );

    // s2 < 2p, so one conditional subtract lands in [0, p-1]; the difference fits 255 bits.
    assign w_ge_p  = (r_s2 >= {1'b0, P_MOD});
    assign w_sub_p = r_s2[254:0] - P_MOD;
    assign w_final = w_ge_p ? w_sub_p : r_s2[254:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h0        <= '0;
            r_l0        <= '0;
            r_m0        <= '0;
            r_p         <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_load_in) begin
                r_h0 <= H0;
                r_l0 <= L0;
                r_m0 <= M0;
            end
            if (w_load_p)  r_p  <= w_p;
            if (w_load_s1) r_s1 <= w_s1;
            if (w_load_s2) r_s2 <= w_s2;
            if (w_load_out) begin
                r_out_data  <= w_final;
                r_out_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef KARA_REDUCE_RAW_OUT_EN
    logic [P_W-1:0] r_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw <= '0;
        end else if (w_load_out) begin
            r_raw <= r_p;
        end
    end

    assign out_raw = r_raw;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_kara_reduce.sv
// Self-checking bench for kara_reduce: directed vectors, random Karatsuba
// triples against a wide-integer X*Y mod p model, backpressure and reset.
module tb_kara_reduce;
    import kara_pkg::*;

    localparam logic [255:0] P_REF   = (256'd1 << 255) - 256'd19;
    localparam int           TIMEOUT = 30;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [253:0]      H0;
    logic [255:0]      L0;
    logic [257:0]      M0;
    logic              out_valid;
    logic              out_ready;
    logic [254:0]      out_data;
    kara_state_e       dbg_state;
`ifdef KARA_REDUCE_RAW_OUT_EN
    logic [509:0]      out_raw;
`endif

    int checks   = 0;
    int failures = 0;

    // Results of the most recent transaction driven by do_txn.
    int           g_lat;
    bit           g_stable;
    logic [254:0] g_data;
    logic [254:0] g_post_data;
    logic         g_post_valid;
    logic         g_post_ready;
    logic [509:0] g_raw;

    always #5 clk = ~clk;

    kara_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .H0        (H0),
        .L0        (L0),
        .M0        (M0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef KARA_REDUCE_RAW_OUT_EN
        .out_raw   (out_raw),
`endif
        .dbg_state (dbg_state)
    );

    function automatic logic [254:0] ref_mulmod(input logic [254:0] x, input logic [254:0] y);
        logic [509:0] xx;
        logic [509:0] yy;
        logic [509:0] pr;
        xx = 510'(x);
        yy = 510'(y);
        pr = xx * yy;
        return 255'(pr % 510'(P_REF));
    endfunction

    task automatic make_triple(input logic [127:0] a1, input logic [126:0] a2,
                               input logic [127:0] b1, input logic [126:0] b2,
                               output logic [253:0] h, output logic [255:0] l,
                               output logic [257:0] m,
                               output logic [254:0] x, output logic [254:0] y);
        h = 254'(a2) * 254'(b2);
        l = 256'(a1) * 256'(b1);
        m = (258'(a1) + 258'(a2)) * (258'(b1) + 258'(b2));
        x = {a2, a1};
        y = {b2, b1};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drives one triple, waits for the result, holds out_ready low for 'hold'
    // cycles, then accepts it. g_lat counts edges from the accept edge inclusive.
    task automatic do_txn(input logic [253:0] h, input logic [255:0] l,
                          input logic [257:0] m, input int hold);
        int n;
        @(negedge clk);
        H0 = h;
        L0 = l;
        M0 = m;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        g_lat = 1;
        while (g_lat < TIMEOUT) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            g_lat++;
        end
        g_data   = out_data;
        g_stable = 1'b1;
`ifdef KARA_REDUCE_RAW_OUT_EN
        g_raw = out_raw;
`else
        g_raw = '0;
`endif
        if (g_lat < TIMEOUT) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (!out_valid || out_data !== g_data || in_ready !== 1'b0) g_stable = 1'b0;
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
        end
        g_post_valid = out_valid;
        g_post_ready = in_ready;
        g_post_data  = out_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        H0 = '0;
        L0 = '0;
        M0 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready_during actual=%b required=0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready_after actual=%b required=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs actual valid=%b data=%h required valid=0 data=0", out_valid, out_data);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state actual=%0d required=%0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic run_directed(input string name, input logic [253:0] h,
                                input logic [255:0] l, input logic [257:0] m,
                                input logic [254:0] exp_data);
        do_txn(h, l, m, 0);
        checks++;
        if (g_lat !== 5) begin
            failures++;
            $display("FAIL %s_latency actual=%0d required=5", name, g_lat);
        end
        checks++;
        if (g_data !== exp_data) begin
            failures++;
            $display("FAIL %s_data actual=%h required=%h", name, g_data, exp_data);
        end
        checks++;
        if (g_post_valid !== 1'b0 || g_post_ready !== 1'b1 || g_post_data !== exp_data) begin
            failures++;
            $display("FAIL %s_post actual valid=%b ready=%b data=%h required valid=0 ready=1 data=%h",
                     name, g_post_valid, g_post_ready, g_post_data, exp_data);
        end
    endtask

    task automatic test_directed();
        logic [255:0] l_p;
        logic [257:0] m_p;
        l_p = (256'd1 << 128) - 256'd19;
        m_p = (258'd1 << 128) + (258'd1 << 127) - 258'd20;
        run_directed("zero", '0, '0, '0, 255'd0);
        run_directed("two_by_three", '0, 256'd6, 258'd6, 255'd6);
        run_directed("pow128_sq", 254'd1, '0, 258'd1, 255'd38);
        run_directed("p_times_one", '0, l_p, m_p, 255'd0);
    endtask

    task automatic test_random();
        logic [127:0] a1, b1;
        logic [126:0] a2, b2;
        logic [253:0] h;
        logic [255:0] l;
        logic [257:0] m;
        logic [254:0] x, y, exp_data;
        for (int i = 0; i < 25; i++) begin
            a1 = rand128();
            b1 = rand128();
            a2 = 127'(rand128());
            b2 = 127'(rand128());
            if (i == 0) begin
                a1 = '1; b1 = '1; a2 = '1; b2 = '1;
            end
            make_triple(a1, a2, b1, b2, h, l, m, x, y);
            exp_data = ref_mulmod(x, y);
            do_txn(h, l, m, $urandom_range(0, 2));
            checks++;
            if (g_lat !== 5 || g_data !== exp_data) begin
                failures++;
                $display("FAIL random_%0d actual lat=%0d data=%h required lat=5 data=%h", i, g_lat, g_data, exp_data);
            end
`ifdef KARA_REDUCE_RAW_OUT_EN
            checks++;
            if (g_raw !== 510'(x) * 510'(y)) begin
                failures++;
                $display("FAIL random_raw_%0d actual=%h required=%h", i, g_raw, 510'(x) * 510'(y));
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [253:0] h;
        logic [255:0] l;
        logic [257:0] m;
        logic [254:0] x, y, exp_data;
        make_triple(rand128(), 127'(rand128()), rand128(), 127'(rand128()), h, l, m, x, y);
        exp_data = ref_mulmod(x, y);
        do_txn(h, l, m, 10);
        checks++;
        if (g_data !== exp_data) begin
            failures++;
            $display("FAIL backpressure_data actual=%h required=%h", g_data, exp_data);
        end
        checks++;
        if (g_stable !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_hold actual stable=%b required=1", g_stable);
        end
        checks++;
        if (g_post_valid !== 1'b0 || g_post_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release actual valid=%b ready=%b required valid=0 ready=1", g_post_valid, g_post_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [253:0] h;
        logic [255:0] l;
        logic [257:0] m;
        logic [254:0] x, y, exp_data;
        bit seen;
        @(negedge clk);
        H0 = '0;
        L0 = 256'd6;
        M0 = 258'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_FOLD1) begin
            failures++;
            $display("FAIL midreset_reach_fold1 actual=%0d required=%0d", dbg_state, ST_FOLD1);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_after actual valid=%b data=%h ready=%b required valid=0 data=0 ready=1",
                     out_valid, out_data, in_ready);
        end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_pulse actual=%b required=0", seen);
        end
        make_triple(rand128(), 127'(rand128()), rand128(), 127'(rand128()), h, l, m, x, y);
        exp_data = ref_mulmod(x, y);
        do_txn(h, l, m, 1);
        checks++;
        if (g_lat !== 5 || g_data !== exp_data) begin
            failures++;
            $display("FAIL midreset_next actual lat=%0d data=%h required lat=5 data=%h", g_lat, g_data, exp_data);
        end
    endtask

    // Triples that break M0 >= H0+L0: data is undefined, timing must not change.
    task automatic test_invalid_inputs();
        for (int i = 0; i < 3; i++) begin
            do_txn({rand128(), 126'(rand128())}, {rand128(), rand128()}, 258'($urandom()), $urandom_range(0, 3));
            checks++;
            if (g_lat !== 5 || g_post_valid !== 1'b0 || g_post_ready !== 1'b1) begin
                failures++;
                $display("FAIL invalid_timing_%0d actual lat=%0d valid=%b ready=%b required lat=5 valid=0 ready=1",
                         i, g_lat, g_post_valid, g_post_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [253:0] h;
        logic [255:0] l;
        logic [257:0] m;
        logic [254:0] x, y, exp_data;
        for (int i = 0; i < 6; i++) begin
            make_triple(rand128(), 127'(rand128()), rand128(), 127'(rand128()), h, l, m, x, y);
            exp_data = ref_mulmod(x, y);
            do_txn(h, l, m, 0);
            checks++;
            if (g_lat !== 5 || g_data !== exp_data || g_post_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d actual lat=%0d data=%h ready=%b required lat=5 data=%h ready=1",
                         i, g_lat, g_data, g_post_ready, exp_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_invalid_inputs();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
